// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller:
// state encoding, opcode/funct constants and ALU codes.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } statetype_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop plus R-type funct onto the 3-bit ALU code.
// funct_valid depends on funct alone so the write-back state can use it too.
module mc_aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_valid
);

  logic [2:0] funct_alu;

  always_comb begin
    funct_alu   = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      F_ADD:   funct_alu = ALU_ADD;
      F_SUB:   funct_alu = ALU_SUB;
      F_AND:   funct_alu = ALU_AND;
      F_OR:    funct_alu = ALU_OR;
      F_SLT:   funct_alu = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = funct_alu;
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing a shared-memory multicycle MIPS datapath (3-5 cycles per instruction).
// state   | meaning
// FETCH   | read instr at PC into IR, PC <= PC+4
// DECODE  | read regs, ALUOut <= branch target, dispatch on op
// MEMADR  | ALUOut <= regA + signimm
// MEMRD   | read data memory at ALUOut
// MEMWB   | rt <= Data reg
// MEMWR   | write regB to memory at ALUOut
// RTYPEEX | ALUOut <= regA funct regB
// RTYPEWB | rd <= ALUOut (skipped for unknown funct)
// BEQEX   | compare regs, PC <= ALUOut if equal
// ADDIEX  | ALUOut <= regA + signimm
// ADDIWB  | rt <= ALUOut
// JEX     | PC <= jump target
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       membyteread,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       instr_done,
  output logic       illegal
);

  statetype_t state_q, state_d;
  aluop_t     aluop;
  logic       funct_valid;
  logic       pcwrite, branch;
  logic       irwrite_c, memwrite_c, regwrite_c, done_c, illegal_c;
  logic       is_lb;

  assign is_lb = (op == OP_LB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= statetype_t'(RESET_STATE);
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = FETCH;
    aluop       = ALUOP_ADD;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    irwrite_c   = 1'b0;
    memwrite_c  = 1'b0;
    regwrite_c  = 1'b0;
    done_c      = 1'b0;
    illegal_c   = 1'b0;
    iord        = 1'b0;
    membyteread = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    case (state_q)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_c = 1'b1;
        pcwrite   = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_LB: state_d = MEMADR;
          OP_RTYPE:            state_d = RTYPEEX;
          OP_BEQ:              state_d = BEQEX;
          OP_ADDI:             state_d = ADDIEX;
          OP_J:                state_d = JEX;
          default: begin
            illegal_c = 1'b1;
            done_c    = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord        = 1'b1;
        membyteread = is_lb;
        state_d     = MEMWB;
      end
      MEMWB: begin
        memtoreg    = 1'b1;
        regwrite_c  = 1'b1;
        membyteread = is_lb;
        done_c      = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
        done_c     = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_c = funct_valid;  // unknown funct retires as a nop
        done_c     = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        done_c  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite_c = 1'b1;
        done_c     = 1'b1;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        done_c  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  mc_aludec u_aludec (
    .aluop       (aluop),
    .funct       (funct),
    .alucontrol  (alucontrol),
    .funct_valid (funct_valid)
  );

  // Write enables and pulses are held off for the whole reset window.
  assign pcen       = ~reset & (pcwrite | (branch & zero));
  assign irwrite    = ~reset & irwrite_c;
  assign memwrite   = ~reset & memwrite_c;
  assign regwrite   = ~reset & regwrite_c;
  assign instr_done = ~reset & done_c;
  assign illegal    = ~reset & illegal_c;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle model checked every cycle,
// plus literal spot checks and a mid-instruction reset.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       membyteread;
    logic       regwrite;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] m_op, m_funct;
  logic       m_zero;
  int         m_k;
  logic       chk_en;
  int         checks = 0;
  int         errors = 0;
  outs_t      obs;
  outs_t      hist [0:4];

  logic       pcen, iord, irwrite, memwrite, membyteread, regwrite, memtoreg;
  logic       regdst, alusrca, instr_done, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .op          (m_op),
    .funct       (m_funct),
    .zero        (m_zero),
    .pcen        (pcen),
    .iord        (iord),
    .irwrite     (irwrite),
    .memwrite    (memwrite),
    .membyteread (membyteread),
    .regwrite    (regwrite),
    .memtoreg    (memtoreg),
    .regdst      (regdst),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .pcsrc       (pcsrc),
    .alucontrol  (alucontrol),
    .instr_done  (instr_done),
    .illegal     (illegal)
  );

  assign obs = {pcen, iord, irwrite, memwrite, membyteread, regwrite, memtoreg, regdst,
                alusrca, alusrcb, pcsrc, alucontrol, instr_done, illegal};

  function automatic int instr_len(input logic [5:0] o);
    case (o)
      6'b100011, 6'b100000:           return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010:           return 3;
      default:                        return 2;
    endcase
  endfunction

  function automatic logic [3:0] rfunct(input logic [5:0] f);
    // {valid, alu code}
    case (f)
      6'b100000: return 4'b1_010;
      6'b100010: return 4'b1_110;
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b101010: return 4'b1_111;
      default:   return 4'b0_010;
    endcase
  endfunction

  // Expected outputs for cycle k (0 = fetch) of an instruction, from the ISA-level rules.
  function automatic outs_t model(input logic [5:0] o, input logic [5:0] f, input logic z, input int k);
    outs_t e;
    logic [3:0] rf;
    e = '0;
    e.alucontrol = 3'b010;
    rf = rfunct(f);
    if (k == 0) begin
      e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1;
    end else if (k == 1) begin
      e.alusrcb = 2'b11;
      if (instr_len(o) == 2) e.illegal = 1'b1;
    end else begin
      case (o)
        6'b100011, 6'b100000, 6'b101011: begin
          if (k == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
          else if (o == 6'b101011) begin e.iord = 1'b1; e.memwrite = 1'b1; end
          else if (k == 3) begin e.iord = 1'b1; e.membyteread = (o == 6'b100000); end
          else begin
            e.regwrite = 1'b1; e.memtoreg = 1'b1; e.membyteread = (o == 6'b100000);
          end
        end
        6'b000000: begin
          if (k == 2) begin e.alusrca = 1'b1; e.alucontrol = rf[2:0]; end
          else begin e.regdst = 1'b1; e.regwrite = rf[3]; end
        end
        6'b000100: begin
          e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z;
        end
        6'b001000: begin
          if (k == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
          else e.regwrite = 1'b1;
        end
        6'b000010: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
        default: ;
      endcase
    end
    if (k >= 1 && k == instr_len(o) - 1) e.instr_done = 1'b1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      outs_t e;
      e = model(m_op, m_funct, m_zero, m_k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL model op=%b funct=%b zero=%b k=%0d got=%h exp=%h",
                 m_op, m_funct, m_zero, m_k, obs, e);
      end
      if (m_k >= 0 && m_k < 5) hist[m_k] = obs;
    end
  end

  task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the last cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    m_op = o; m_funct = f; m_zero = z;
    for (int k = 0; k < instr_len(o); k++) begin
      m_k = k;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; chk_en = 1'b0; m_op = 6'b0; m_funct = 6'b0; m_zero = 1'b0; m_k = 0;
    @(posedge clk); #1;
    check_lit("reset_pcen", {7'b0, pcen}, 8'd0);
    check_lit("reset_irwrite", {7'b0, irwrite}, 8'd0);
    @(posedge clk); #1;
    reset = 1'b0; chk_en = 1'b1;

    run_instr(6'b100011, 6'b000000, 1'b1);  // lw
    check_lit("lw_memrd_iord", {7'b0, hist[3].iord}, 8'd1);
    check_lit("lw_wb_regwrite_memtoreg", {6'b0, hist[4].regwrite, hist[4].memtoreg}, 8'd3);
    run_instr(6'b100000, 6'b000000, 1'b0);  // lb
    check_lit("lb_memrd_byte", {7'b0, hist[3].membyteread}, 8'd1);
    run_instr(6'b101011, 6'b000000, 1'b0);  // sw
    check_lit("sw_memwrite", {7'b0, hist[3].memwrite}, 8'd1);
    run_instr(6'b000000, 6'b100010, 1'b1);  // sub
    check_lit("rtype_sub_alu", {5'b0, hist[2].alucontrol}, 8'h06);
    run_instr(6'b000000, 6'b101010, 1'b0);  // slt
    check_lit("rtype_slt_alu", {5'b0, hist[2].alucontrol}, 8'h07);
    check_lit("rtype_wb_regdst", {6'b0, hist[3].regwrite, hist[3].regdst}, 8'd3);
    run_instr(6'b000000, 6'b100000, 1'b1);  // add
    run_instr(6'b000000, 6'b100100, 1'b0);  // and
    run_instr(6'b000000, 6'b100101, 1'b0);  // or
    run_instr(6'b000000, 6'b000000, 1'b0);  // unknown funct
    check_lit("rtype_nop_regwrite", {7'b0, hist[3].regwrite}, 8'd0);
    run_instr(6'b000100, 6'b000000, 1'b1);  // beq taken
    check_lit("beq_taken_pcen", {7'b0, hist[2].pcen}, 8'd1);
    run_instr(6'b000100, 6'b000000, 1'b0);  // beq not taken
    check_lit("beq_nottaken_pcen", {7'b0, hist[2].pcen}, 8'd0);
    run_instr(6'b001000, 6'b000000, 1'b1);  // addi
    run_instr(6'b000010, 6'b000000, 1'b1);  // j
    check_lit("j_pcsrc", {6'b0, hist[2].pcsrc}, 8'd2);
    run_instr(6'b111111, 6'b000000, 1'b1);  // illegal
    check_lit("illegal_pulse", {7'b0, hist[1].illegal}, 8'd1);
    run_instr(6'b000001, 6'b100010, 1'b0);  // illegal
    run_instr(6'b001000, 6'b000000, 1'b0);  // addi after illegal

    // lw aborted by reset in MEMRD
    m_op = 6'b100011; m_funct = 6'b0; m_zero = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_k = k;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    m_k = 3;
    check_lit("abort_in_memrd_iord", {7'b0, iord}, 8'd1);
    chk_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_lit("abort_async_iord", {7'b0, iord}, 8'd0);
    check_lit("abort_async_alusrcb", {6'b0, alusrcb}, 8'd1);
    check_lit("abort_enables", {3'b0, pcen, irwrite, regwrite, memwrite, instr_done}, 8'd0);
    @(posedge clk); #1;
    check_lit("reset_hold_enables", {2'b0, pcen, irwrite, regwrite, memwrite, instr_done, illegal}, 8'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_lit("release_fetch", {pcen, irwrite, alusrcb, 1'b0, alucontrol}, 8'b1101_0010);
    chk_en = 1'b1;
    run_instr(6'b101011, 6'b000000, 1'b1);  // sw after reset
    run_instr(6'b000000, 6'b100101, 1'b1);  // or

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
